// File: rtl/ms_d_ff_pkg.sv
// Shared definitions for the master-slave D flip-flop slice.
package ms_d_ff_pkg;

    // Default number of bit-slices when the user does not override WIDTH.
    localparam int DEFAULT_WIDTH = 1;

    // Next-state selection for one bit-slice: reset value wins over data.
    function automatic logic next_bit(input logic rst, input logic rst_bit, input logic d_bit);
        return rst ? rst_bit : d_bit;
    endfunction

endpackage : ms_d_ff_pkg

// File: rtl/ms_d_ff_d_latch.sv
// Level-sensitive latch: q follows d while en is high, holds while en is low.
module d_latch #(
    parameter int WIDTH = 1
) (
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    // Transparent while en=1, storage element while en=0.
    always_latch begin
        if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule : d_latch

// File: rtl/ms_d_ff.sv
// Edge-triggered D flip-flop built from an explicit master/slave latch pair
// per bit, with a synchronous active-high reset folded into the master input.
module ms_d_ff
    import ms_d_ff_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Master latch input: the value Q must take at the next rising edge.
    logic [WIDTH-1:0] master_d;
    // Master latch output, handed to the slave.
    logic [WIDTH-1:0] master_q;
    // Slave latch output, which is the flop output.
    logic [WIDTH-1:0] slave_q;
    // Enables: master open while clk is low, slave open while clk is high.
    logic             master_en;
    logic             slave_en;

    assign master_en = ~clk;
    assign slave_en  = clk;

    // Reset is only a data-path mux; it reaches Q solely through the latches,
    // so it has no effect between rising edges.
    always_comb begin
        master_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            master_d[i] = next_bit(reset, RESET_VAL[i], D[i]);
        end
    end

    // One independent master/slave pair per bit-slice.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
            d_latch #(
                .WIDTH (1)
            ) u_master (
                .en (master_en),
                .d  (master_d[gi]),
                .q  (master_q[gi])
            );

            d_latch #(
                .WIDTH (1)
            ) u_slave (
                .en (slave_en),
                .d  (master_q[gi]),
                .q  (slave_q[gi])
            );
        end
    endgenerate

    assign Q = slave_q;

endmodule : ms_d_ff

// File: tb/tb_ms_d_ff.sv
// Scoreboard bench for ms_d_ff: a 1-bit instance with zero reset value and a
// 4-bit instance with reset value 4'hA share reset and a per-vector data set.
module tb_ms_d_ff;

    logic       clk;
    logic       reset;
    logic       d1;
    logic [3:0] d4;
    logic       q1;
    logic [3:0] q4;

    ms_d_ff u_dut1 (
        .clk   (clk),
        .reset (reset),
        .D     (d1),
        .Q     (q1)
    );

    ms_d_ff #(
        .WIDTH     (4),
        .RESET_VAL (4'hA)
    ) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .D     (d4),
        .Q     (q4)
    );

    // Rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       d1;
        logic [3:0] d4;
        logic       disturb; // toggle D and pulse reset while clk is high
        logic       e1;      // hand-computed Q of the 1-bit instance after the edge
        logic [3:0] e4;      // hand-computed Q of the 4-bit instance after the edge
    } vec_t;

    typedef struct {
        int         idx;
        logic       e1;
        logic [3:0] e4;
    } exp_t;

    localparam int NV = 13;
    vec_t vecs [NV];
    exp_t exp_q [$];

    int n_cmp;
    int n_err;

    initial begin
        //          rst   d1    d4     dist  e1    e4
        vecs[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'hA}; // reset state
        vecs[1]  = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 4'h3}; // capture
        vecs[2]  = '{1'b0, 1'b0, 4'hC, 1'b1, 1'b0, 4'hC}; // glitches while high ignored
        vecs[3]  = '{1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 4'hF};
        vecs[4]  = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 4'hF}; // reset pulse between edges
        vecs[5]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
        vecs[6]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
        vecs[7]  = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 4'hA}; // reset beats D
        vecs[8]  = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 4'h5}; // D after reset release
        vecs[9]  = '{1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 4'h5};
        vecs[10] = '{1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 4'hA}; // sync reset from non-reset state
        vecs[11] = '{1'b0, 1'b0, 4'h6, 1'b0, 1'b0, 4'h6};
        vecs[12] = '{1'b0, 1'b1, 4'h9, 1'b1, 1'b1, 4'h9};
    end

    // Stimulus: new vector at each falling edge (t = 10*i), pushes the
    // expected result for the following rising edge, then optionally
    // disturbs D and reset during the high phase after that edge.
    task automatic run_stimulus();
        reset = 1'b1;
        d1    = 1'b0;
        d4    = 4'h0;
        #0;
        for (int i = 0; i < NV; i++) begin
            reset = vecs[i].rst;
            d1    = vecs[i].d1;
            d4    = vecs[i].d4;
            exp_q.push_back('{idx: i, e1: vecs[i].e1, e4: vecs[i].e4});
            #6; // 10*i + 6, clk high
            if (vecs[i].disturb) begin
                reset = ~vecs[i].rst;
                d1    = ~vecs[i].d1;
                d4    = ~vecs[i].d4;
            end
            #2; // 10*i + 8, clk high
            reset = vecs[i].rst;
            d1    = vecs[i].d1;
            d4    = vecs[i].d4;
            #2; // 10*i + 10, falling edge
        end
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] act,
                         input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s vec %0d: Q=%h required %h", name, idx, act, req);
        end else begin
            $display("ok   %s vec %0d: Q=%h", name, idx, act);
        end
    endtask

    // Monitor: after each rising edge checks Q right after the edge (clk high,
    // during any disturbance) and again in the following low phase while the
    // next vector is already on D (master transparent, slave must hold).
    task automatic run_monitor();
        exp_t e;
        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard: no expected entry at edge %0d (required 1 entry)", i);
            end else begin
                e = exp_q.pop_front();
                check("q1_edge", e.idx, {3'b000, q1}, {3'b000, e.e1});
                check("q4_edge", e.idx, q4, e.e4);
                #7;
                check("q1_hold", e.idx, {3'b000, q1}, {3'b000, e.e1});
                check("q4_hold", e.idx, q4, e.e4);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        fork
            run_stimulus();
            run_monitor();
        join
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #5000;
        $display("FAIL timeout: simulation reached 5000 time units, required earlier finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

endmodule : tb_ms_d_ff
